matmul_stream_driver: RTL and testbench
=======================================

Name: matmul_stream_driver

Overview:
- Initiator-side companion to the matrix compute core: holds operand matrices A (2xK) and B (Kx2) written by a host, streams them out on two AXI-Stream masters, and captures the 2x2 result C from an AXI-Stream slave.
- Drives the core's start and observes its done.
- Sits between the host register/memory interface and the compute core. Primary use: block-level bring-up and system integration.

Parameters:
- DATA_W, 32, width of every data word (operands, stream beats, results).
- K_MAX, 2, maximum inner dimension K; sizes the A/B buffers.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  host buffer write strobe.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_addr  in  $clog2(2*K_MAX)  row-major word index into the selected buffer.
- wr_data  in  DATA_W  host write data.
- rd_addr  in  2  result index: 0=C00, 1=C01, 2=C10, 3=C11.
- rd_data  out  DATA_W  result word, combinational read of the result buffer.
- cfg_k  in  $clog2(K_MAX)+1  inner dimension; sampled on go.
- go  in  1  starts one transaction; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- err  out  1  sticky error flag; cleared on the next accepted go.
- core_start  out  1  start level to the compute core.
- core_done  in  1  done from the compute core.
- m_axis_a_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  A operand stream.
- m_axis_b_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  B operand stream.
- s_axis_c_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  C result stream.

Behaviour:
- **Reset:** state IDLE. All valid, tready, tlast, core_start, done, busy and err outputs are 0. All counters are 0. Buffer contents are not reset.
- **Host writes:** accepted only in IDLE; ignored otherwise.
  - A is stored row-major: addr = r*K_MAX + k.
  - B is stored row-major: addr = k*2 + c.
  - Addresses >= 2*K_MAX are ignored.
- **go acceptance:** go in IDLE with 1 <= cfg_k <= K_MAX latches K, clears err and enters SEND_A.
  - If cfg_k is out of range: set err, stay IDLE, no core_start.
- **SEND_A:**
  - core_start=1; it remains 1 through RECV_C.
  - m_axis_a_tvalid=1. Beats are sent in order A[0][0..K-1], then A[1][0..K-1], for 2K beats total.
  - tlast=1 on beat 2K-1.
  - tdata/tlast stay stable while tvalid && !tready. The beat index advances only on tvalid&&tready.
  - The last handshake moves to SEND_B. There is no idle cycle between A beats under continuous tready.
- **SEND_B:** same rules as SEND_A, order B[0][0], B[0][1], B[1][0], … , for 2K beats; last handshake moves to RECV_C.
- **RECV_C:**
  - s_axis_c_tready=1. Each handshake writes tdata to result[c_idx], then c_idx increments.
  - tlast must coincide with c_idx==3. Early tlast, or a missing tlast on beat 3, sets err. The block still ends after exactly 4 beats.
  - After beat 3 it moves to WAIT_DONE.
- **WAIT_DONE:** core_start=0. When core_done==1, move to FINISH.
  - If core_done is already high on entry, it is accepted in the same cycle.
- **FINISH:** done=1 for one cycle, then IDLE. The core sees start low and returns to its idle state.
- **Stream ports:** all AXI-Stream outputs are registered-stable; only one of A, B or C is ever active at a time.
- **Other conditions:**
  - go while busy is ignored.
  - rst mid-transaction returns to IDLE in the next cycle and drops all valids and core_start; the partial result is undefined.
  - tready toggling every cycle must not drop, duplicate or reorder beats.
- **Latency:** with tready always high and C returned immediately, go to done = 4K + 4 + 3 cycles.

Decomposition:
- Package matmul_pkg holds:
  - the state enum (IDLE, SEND_A, SEND_B, RECV_C, WAIT_DONE, FINISH);
  - the C beat count constant (4);
  - the DATA_W/K_MAX defaults shared with the compute core.
- Sub-module axis_tx_seq is the natural unit: an index counter plus tvalid/tlast generator with stall-hold. It is instantiated twice, for A and for B.

Test Plan:
1. Load A={1,2,3,4}, B={5,6,7,8}, cfg_k=2, go, all tready=1, C beats {19,22,43,50} with tlast on 4th -> A beats 1,2,3,4 with tlast on 4; B beats 5,6,7,8 with tlast on 4; rd_data[0..3]=19,22,43,50; done pulses once; err=0.
2. Same transfer with m_axis_a_tready toggling 1010 and B tready held 0 for 5 cycles -> identical beat sequence, no duplicates, tdata stable during stalls.
3. cfg_k=1, A={3,4}, B={5,6} -> 2 A beats (tlast on 2nd), 2 B beats; C capture still 4 beats.
4. cfg_k=0, go -> err=1, busy stays 0, core_start never asserted. Then a valid go clears err.
5. C tlast asserted on beat 2 -> err=1, block still takes 4 beats, done pulses.
6. rst asserted mid SEND_B -> next cycle: all tvalid=0, core_start=0, busy=0. A fresh transaction then completes correctly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix compute core and its stream driver.
package matmul_pkg;

  localparam int unsigned MM_DATA_W = 32;
  localparam int unsigned MM_K_MAX  = 2;
  localparam int unsigned C_BEATS   = 4;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    RECV_C,
    WAIT_DONE,
    FINISH
  } state_t;

endpackage

// File: rtl/axis_tx_seq.sv
// AXI-Stream transmit sequencer: beat index counter with tvalid/tlast generation.
// The index only moves on a handshake, so the addressed word and tlast hold
// steady through backpressure.
module axis_tx_seq #(
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             tready,
  output logic             tvalid,
  output logic             tlast,
  output logic [IDX_W-1:0] idx,
  output logic             fin
);

  assign tvalid = active;
  assign tlast  = active && (idx == last_idx);
  assign fin    = tvalid && tready && tlast;

  // Beat index: advance on handshake, back to zero after the last beat or when idle
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      idx <= '0;
    end else if (tready) begin
      idx <= tlast ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_stream_driver.sv
// Initiator-side driver for the matrix compute core: buffers host-written A/B
// operands, streams them to the core, captures the 2x2 result stream.
module matmul_stream_driver
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W = MM_DATA_W,
  parameter int unsigned K_MAX  = MM_K_MAX
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic                        wr_sel,
  input  logic [$clog2(2*K_MAX)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [1:0]                  rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  input  logic [$clog2(K_MAX):0]      cfg_k,
  input  logic                        go,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        core_start,
  input  logic                        core_done,
  output logic [DATA_W-1:0]           m_axis_a_tdata,
  output logic                        m_axis_a_tvalid,
  input  logic                        m_axis_a_tready,
  output logic                        m_axis_a_tlast,
  output logic [DATA_W-1:0]           m_axis_b_tdata,
  output logic                        m_axis_b_tvalid,
  input  logic                        m_axis_b_tready,
  output logic                        m_axis_b_tlast,
  input  logic [DATA_W-1:0]           s_axis_c_tdata,
  input  logic                        s_axis_c_tvalid,
  output logic                        s_axis_c_tready,
  input  logic                        s_axis_c_tlast
);

  localparam int unsigned AW = $clog2(2*K_MAX);
  localparam int unsigned KW = $clog2(K_MAX) + 1;
  localparam int unsigned NW = 2 * K_MAX;
  localparam int unsigned CW = $clog2(C_BEATS);

  state_t state, state_nxt;

  logic [KW-1:0]     k_reg;
  logic [CW-1:0]     c_idx;
  logic [DATA_W-1:0] a_buf   [NW];
  logic [DATA_W-1:0] b_buf   [NW];
  logic [DATA_W-1:0] res_buf [C_BEATS];

  logic          cfg_ok, go_ok, c_hs;
  logic          a_active, b_active, a_fin, b_fin;
  logic          a_valid_unused, b_valid_unused;
  logic [AW-1:0] a_idx, b_idx, a_addr, last_beat;

  assign cfg_ok    = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
  assign go_ok     = (state == IDLE) && go && cfg_ok;
  assign last_beat = AW'(2 * int'(k_reg) - 1);

  // Stream enables decode straight from the state register so they are glitch-free
  assign a_active        = (state == SEND_A);
  assign b_active        = (state == SEND_B);
  assign s_axis_c_tready = (state == RECV_C);
  assign c_hs            = s_axis_c_tvalid && s_axis_c_tready;

  // A is stored with a K_MAX row pitch; beats past K step over to the second row
  always_comb begin
    if (a_idx < AW'(k_reg)) begin
      a_addr = a_idx;
    end else begin
      a_addr = AW'(K_MAX) + a_idx - AW'(k_reg);
    end
  end

  assign m_axis_a_tvalid = a_valid_unused;
  assign m_axis_b_tvalid = b_valid_unused;
  assign m_axis_a_tdata  = a_buf[a_addr];
  assign m_axis_b_tdata  = b_buf[b_idx];
  assign rd_data         = res_buf[rd_addr];

  axis_tx_seq #(.IDX_W(AW)) u_tx_a (
    .clk      (clk),
    .rst      (rst),
    .active   (a_active),
    .last_idx (last_beat),
    .tready   (m_axis_a_tready),
    .tvalid   (a_valid_unused),
    .tlast    (m_axis_a_tlast),
    .idx      (a_idx),
    .fin      (a_fin)
  );

  axis_tx_seq #(.IDX_W(AW)) u_tx_b (
    .clk      (clk),
    .rst      (rst),
    .active   (b_active),
    .last_idx (last_beat),
    .tready   (m_axis_b_tready),
    .tvalid   (b_valid_unused),
    .tlast    (m_axis_b_tlast),
    .idx      (b_idx),
    .fin      (b_fin)
  );

  // Host operand writes land only while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE) && (32'(wr_addr) < NW)) begin
      if (wr_sel) begin
        b_buf[wr_addr] <= wr_data;
      end else begin
        a_buf[wr_addr] <= wr_data;
      end
    end
  end

  // Result capture, one word per C handshake
  always_ff @(posedge clk) begin
    if (c_hs) begin
      res_buf[c_idx] <= s_axis_c_tdata;
    end
  end

  // Transaction bookkeeping: latched K, C beat index, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg <= '0;
      c_idx <= '0;
      err   <= 1'b0;
    end else begin
      if ((state == IDLE) && go) begin
        if (cfg_ok) begin
          k_reg <= cfg_k;
          err   <= 1'b0;
        end else begin
          err   <= 1'b1;
        end
      end
      if (c_hs) begin
        c_idx <= c_idx + 1'b1;
        if (s_axis_c_tlast != (c_idx == CW'(C_BEATS - 1))) begin
          err <= 1'b1;
        end
      end else if (state != RECV_C) begin
        c_idx <= '0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go_ok) state_nxt = SEND_A;
      end
      SEND_A: begin
        core_start = 1'b1;
        if (a_fin) state_nxt = SEND_B;
      end
      SEND_B: begin
        core_start = 1'b1;
        if (b_fin) state_nxt = RECV_C;
      end
      RECV_C: begin
        core_start = 1'b1;
        if (s_axis_c_tvalid && (c_idx == CW'(C_BEATS - 1))) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_done) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_stream_driver.sv
// Self-checking bench for matmul_stream_driver: the bench plays host, compute
// core and stream peers, and predicts streams and results from matrix math.
module tb_matmul_stream_driver;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned K_MAX  = 2;
  localparam int unsigned AW     = $clog2(2*K_MAX);
  localparam int unsigned KW     = $clog2(K_MAX) + 1;

  logic              clk = 1'b0;
  logic              rst, wr_en, wr_sel, go, core_done;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [1:0]        rd_addr;
  logic [KW-1:0]     cfg_k;
  logic              busy, done, err, core_start;
  logic [DATA_W-1:0] m_axis_a_tdata, m_axis_b_tdata, s_axis_c_tdata;
  logic              m_axis_a_tvalid, m_axis_a_tready, m_axis_a_tlast;
  logic              m_axis_b_tvalid, m_axis_b_tready, m_axis_b_tlast;
  logic              s_axis_c_tvalid, s_axis_c_tready, s_axis_c_tlast;

  always #5 clk = ~clk;

  matmul_stream_driver #(.DATA_W(DATA_W), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cfg_k(cfg_k), .go(go), .busy(busy), .done(done), .err(err),
    .core_start(core_start), .core_done(core_done),
    .m_axis_a_tdata(m_axis_a_tdata), .m_axis_a_tvalid(m_axis_a_tvalid),
    .m_axis_a_tready(m_axis_a_tready), .m_axis_a_tlast(m_axis_a_tlast),
    .m_axis_b_tdata(m_axis_b_tdata), .m_axis_b_tvalid(m_axis_b_tvalid),
    .m_axis_b_tready(m_axis_b_tready), .m_axis_b_tlast(m_axis_b_tlast),
    .s_axis_c_tdata(s_axis_c_tdata), .s_axis_c_tvalid(s_axis_c_tvalid),
    .s_axis_c_tready(s_axis_c_tready), .s_axis_c_tlast(s_axis_c_tlast)
  );

  int checks = 0;
  int errors = 0;

  // Host's view of the operand buffers
  logic [DATA_W-1:0] a_mem [2*K_MAX];
  logic [DATA_W-1:0] b_mem [2*K_MAX];

  // Observations from the most recent transaction
  logic [DATA_W-1:0] a_seen[$];
  logic [DATA_W-1:0] b_seen[$];
  bit                a_last_seen[$];
  bit                b_last_seen[$];
  int                done_cnt;
  int                lat_cycles;
  bit                err_after_go;

  task automatic quiet_inputs();
    wr_en = 1'b0; go = 1'b0; core_done = 1'b0;
    m_axis_a_tready = 1'b0; m_axis_b_tready = 1'b0;
    s_axis_c_tvalid = 1'b0; s_axis_c_tlast = 1'b0; s_axis_c_tdata = '0;
  endtask

  task automatic host_write(input bit sel, input int addr, input logic [DATA_W-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel) b_mem[addr] = data; else a_mem[addr] = data;
  endtask

  task automatic load_random();
    for (int i = 0; i < 2*K_MAX; i++) begin
      host_write(1'b0, i, $urandom);
      host_write(1'b1, i, $urandom);
    end
  endtask

  // C[r][c] = sum over j of A[r][j] * B[j][c]
  function automatic logic [DATA_W-1:0] c_ref(input int k, input int idx);
    logic [DATA_W-1:0] s;
    int r;
    int c;
    s = '0;
    r = idx / 2;
    c = idx % 2;
    for (int j = 0; j < k; j++) s += a_mem[r*K_MAX + j] * b_mem[j*2 + c];
    return s;
  endfunction

  // One transaction: a_mode/b_mode 0=always ready, 1=toggle 1010, 2=random, 3=hold 0 for 5 cycles.
  // c_tl = C beat carrying tlast (-1 = none). abort_b >= 0 pulses rst once that many B beats are taken.
  task automatic run_txn(input int k, input int a_mode, input int b_mode, input int c_tl,
                         input bit c_gap, input int core_delay, input bit junk, input int abort_b);
    logic [DATA_W-1:0] cvals [4];
    logic [DATA_W-1:0] a_hold, b_hold, exp_d;
    bit a_hold_last, b_hold_last, a_stall, b_stall, a_r, b_r;
    bit c_valid, started, finished, aborted;
    int c_sent, b_left, wait_cnt, cyc, j;

    for (int i = 0; i < 4; i++) cvals[i] = c_ref(k, i);
    a_seen.delete(); b_seen.delete(); a_last_seen.delete(); b_last_seen.delete();
    done_cnt = 0; lat_cycles = 0;
    a_stall = 0; b_stall = 0; c_valid = 0; started = 0; finished = 0; aborted = 0;
    a_hold = '0; b_hold = '0; a_hold_last = 0; b_hold_last = 0;
    c_sent = 0; b_left = 5; wait_cnt = 0;

    cfg_k = KW'(k); go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    err_after_go = err;
    cyc = 2;

    for (int n = 0; n < 300 && !finished; n++) begin
      case (a_mode)
        0: a_r = 1'b1;
        1: a_r = (n % 2 == 0);
        default: a_r = 1'($urandom);
      endcase
      case (b_mode)
        0: b_r = 1'b1;
        1: b_r = (n % 2 == 0);
        3: begin
          b_r = 1'b1;
          if (m_axis_b_tvalid && b_left > 0) begin b_r = 1'b0; b_left--; end
        end
        default: b_r = 1'($urandom);
      endcase
      m_axis_a_tready = a_r;
      m_axis_b_tready = b_r;
      if (!c_valid && c_sent < 4) c_valid = c_gap ? 1'($urandom) : 1'b1;
      s_axis_c_tvalid = c_valid;
      s_axis_c_tdata  = (c_sent < 4) ? cvals[c_sent] : $urandom;
      s_axis_c_tlast  = c_valid && (c_sent == c_tl);
      core_done = started && !core_start && (wait_cnt >= core_delay);
      if (junk && busy) begin
        wr_en = 1'($urandom); wr_sel = 1'($urandom); wr_addr = AW'($urandom); wr_data = $urandom;
        go = 1'($urandom); cfg_k = KW'($urandom);
      end else begin
        wr_en = 1'b0; go = 1'b0;
      end
      #1;

      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy_during_txn cycle %0d got %b exp 1", cyc, busy);
      end
      checks++;
      if (int'(m_axis_a_tvalid) + int'(m_axis_b_tvalid) + int'(s_axis_c_tready) > 1) begin
        errors++;
        $display("FAIL stream_exclusive cycle %0d got a=%b b=%b c=%b exp at most one",
                 cyc, m_axis_a_tvalid, m_axis_b_tvalid, s_axis_c_tready);
      end

      if (m_axis_a_tvalid) begin
        if (a_stall) begin
          checks++;
          if (m_axis_a_tdata !== a_hold || m_axis_a_tlast !== a_hold_last) begin
            errors++;
            $display("FAIL a_stall_hold got %0h/%b exp %0h/%b", m_axis_a_tdata, m_axis_a_tlast, a_hold, a_hold_last);
          end
        end
        if (a_r) begin
          a_seen.push_back(m_axis_a_tdata); a_last_seen.push_back(m_axis_a_tlast); a_stall = 0;
        end else begin
          a_stall = 1; a_hold = m_axis_a_tdata; a_hold_last = m_axis_a_tlast;
        end
      end else a_stall = 0;

      if (m_axis_b_tvalid) begin
        if (b_stall) begin
          checks++;
          if (m_axis_b_tdata !== b_hold || m_axis_b_tlast !== b_hold_last) begin
            errors++;
            $display("FAIL b_stall_hold got %0h/%b exp %0h/%b", m_axis_b_tdata, m_axis_b_tlast, b_hold, b_hold_last);
          end
        end
        if (b_r) begin
          b_seen.push_back(m_axis_b_tdata); b_last_seen.push_back(m_axis_b_tlast); b_stall = 0;
        end else begin
          b_stall = 1; b_hold = m_axis_b_tdata; b_hold_last = m_axis_b_tlast;
        end
      end else b_stall = 0;

      if (c_valid && s_axis_c_tready) begin c_sent++; c_valid = 0; end
      if (core_start) started = 1;
      else if (started) wait_cnt++;
      if (done) begin
        done_cnt++;
        if (lat_cycles == 0) lat_cycles = cyc;
      end

      if (abort_b >= 0 && m_axis_b_tvalid && b_seen.size() == abort_b) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        quiet_inputs();
        aborted = 1;
        checks++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, s_axis_c_tready, core_start, busy} !== 5'b0) begin
          errors++;
          $display("FAIL abort_idle got a=%b b=%b c=%b start=%b busy=%b exp all 0",
                   m_axis_a_tvalid, m_axis_b_tvalid, s_axis_c_tready, core_start, busy);
        end
        break;
      end

      @(posedge clk); #1;
      cyc++;
      if (done_cnt > 0) finished = 1;
    end
    quiet_inputs();
    if (aborted) return;

    checks++;
    if (!finished) begin
      errors++; $display("FAIL txn_timeout got no done within budget exp done");
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_done_idle got busy=%b done=%b exp 0/0", busy, done);
    end

    checks++;
    if (a_seen.size() != 2*k || b_seen.size() != 2*k) begin
      errors++; $display("FAIL beat_count got a=%0d b=%0d exp %0d", a_seen.size(), b_seen.size(), 2*k);
    end
    j = 0;
    for (int r = 0; r < 2; r++) begin
      for (int kk = 0; kk < k; kk++) begin
        if (j < a_seen.size()) begin
          exp_d = a_mem[r*K_MAX + kk];
          checks++;
          if (a_seen[j] !== exp_d || a_last_seen[j] !== (j == 2*k-1)) begin
            errors++; $display("FAIL a_beat%0d got %0h/%b exp %0h/%b", j, a_seen[j], a_last_seen[j], exp_d, j == 2*k-1);
          end
        end
        j++;
      end
    end
    j = 0;
    for (int kk = 0; kk < k; kk++) begin
      for (int c = 0; c < 2; c++) begin
        if (j < b_seen.size()) begin
          exp_d = b_mem[kk*2 + c];
          checks++;
          if (b_seen[j] !== exp_d || b_last_seen[j] !== (j == 2*k-1)) begin
            errors++; $display("FAIL b_beat%0d got %0h/%b exp %0h/%b", j, b_seen[j], b_last_seen[j], exp_d, j == 2*k-1);
          end
        end
        j++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++;
      if (rd_data !== cvals[i]) begin
        errors++; $display("FAIL result%0d got %0h exp %0h", i, rd_data, cvals[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({m_axis_a_tvalid, m_axis_a_tlast, m_axis_b_tvalid, m_axis_b_tlast, s_axis_c_tready} !== 5'b0) begin
      errors++; $display("FAIL reset_streams got %b exp 00000",
                         {m_axis_a_tvalid, m_axis_a_tlast, m_axis_b_tvalid, m_axis_b_tlast, s_axis_c_tready});
    end
    checks++;
    if ({core_start, done, busy, err} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {core_start, done, busy, err});
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      host_write(1'b0, i, DATA_W'(i + 1));
      host_write(1'b1, i, DATA_W'(i + 5));
    end
    run_txn(2, 0, 0, 3, 0, 0, 0, -1);
    checks++;
    if (c_ref(2, 0) !== 32'd19 || c_ref(2, 3) !== 32'd50) begin
      errors++; $display("FAIL basic_model got %0d/%0d exp 19/50", c_ref(2, 0), c_ref(2, 3));
    end
    checks++;
    if (lat_cycles != 4*2 + 7) begin
      errors++; $display("FAIL basic_latency got %0d exp %0d", lat_cycles, 4*2 + 7);
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin
      errors++; $display("FAIL basic_done_err got done=%0d err=%b exp 1/0", done_cnt, err);
    end
  endtask

  task automatic test_backpressure();
    run_txn(2, 1, 3, 3, 0, 0, 1, -1);
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin
      errors++; $display("FAIL stall_done_err got done=%0d err=%b exp 1/0", done_cnt, err);
    end
  endtask

  task automatic test_k1();
    host_write(1'b0, 0, 32'd3);
    host_write(1'b0, 2, 32'd4);
    host_write(1'b1, 0, 32'd5);
    host_write(1'b1, 1, 32'd6);
    run_txn(1, 0, 0, 3, 0, 0, 0, -1);
    checks++;
    if (lat_cycles != 4*1 + 7) begin
      errors++; $display("FAIL k1_latency got %0d exp %0d", lat_cycles, 4*1 + 7);
    end
  endtask

  task automatic test_bad_k();
    logic [KW-1:0] bad [2];
    bad[0] = '0;
    bad[1] = KW'(K_MAX + 1);
    for (int t = 0; t < 2; t++) begin
      cfg_k = bad[t]; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      checks++;
      if (err !== 1'b1) begin
        errors++; $display("FAIL bad_k_err cfg_k=%0d got %b exp 1", bad[t], err);
      end
      for (int n = 0; n < 3; n++) begin
        checks++;
        if (busy !== 1'b0 || core_start !== 1'b0) begin
          errors++; $display("FAIL bad_k_idle got busy=%b start=%b exp 0/0", busy, core_start);
        end
        @(posedge clk); #1;
      end
    end
    run_txn(2, 0, 0, 3, 0, 0, 0, -1);
    checks++;
    if (err_after_go !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL bad_k_clear got %b/%b exp 0/0", err_after_go, err);
    end
  endtask

  task automatic test_core_wait();
    run_txn(2, 0, 0, 3, 0, 3, 0, -1);
    checks++;
    if (lat_cycles != 4*2 + 7 + 3) begin
      errors++; $display("FAIL core_wait_latency got %0d exp %0d", lat_cycles, 4*2 + 7 + 3);
    end
  endtask

  task automatic test_bad_tlast();
    run_txn(2, 0, 0, 1, 0, 0, 0, -1);
    checks++;
    if (err !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL early_tlast got err=%b done=%0d exp 1/1", err, done_cnt);
    end
    run_txn(1, 0, 0, -1, 1, 0, 0, -1);
    checks++;
    if (err_after_go !== 1'b0 || err !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL missing_tlast got clr=%b err=%b done=%0d exp 0/1/1", err_after_go, err, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    load_random();
    run_txn(2, 0, 0, 3, 0, 0, 0, 1);
    load_random();
    run_txn(2, 2, 2, 3, 1, 1, 0, -1);
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin
      errors++; $display("FAIL after_abort got done=%0d err=%b exp 1/0", done_cnt, err);
    end
  endtask

  task automatic test_random();
    int k;
    for (int it = 0; it < 6; it++) begin
      load_random();
      k = int'($urandom_range(K_MAX, 1));
      run_txn(k, 2, 2, 3, 1, int'($urandom_range(3, 0)), 1, -1);
      checks++;
      if (done_cnt != 1 || err !== 1'b0) begin
        errors++; $display("FAIL random%0d got done=%0d err=%b exp 1/0", it, done_cnt, err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; cfg_k = '0;
    quiet_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_k1();
    test_bad_k();
    test_core_wait();
    test_bad_tlast();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
